// File: rtl/hwag_pkg.sv
// Shared constants and types for the HWAG crank-signal path.
// Contents: counter widths, default wheel geometry (60-2), smallest
// accepted generator period, and the crank wheel generator state type.
package hwag_pkg;

    localparam int PCNT_WIDTH     = 24;  // tooth period counter width
    localparam int TCNT_WIDTH     = 8;   // tooth slot index width
    localparam int HWAG_TOOTH_NUM = 60;  // slots per revolution, gap included
    localparam int HWAG_GAP_TEETH = 2;   // missing teeth at end of revolution
    localparam int CWG_PERIOD_MIN = 4;   // shortest slot the generator will emit

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        GAP
    } cwg_state_t;

endpackage

// File: rtl/counting.sv
// counter_compare: free-running up-counter with synchronous clear and a
// terminal-value compare.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous reset, active-low (count -> 0)
//   en    in   count enable
//   srst  in   synchronous clear, wins over en
//   dtop  in   terminal value
//   cnt   out  current count
//   hit   out  cnt == dtop
module counter_compare #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             srst,
    input  logic [WIDTH-1:0] dtop,
    output logic [WIDTH-1:0] cnt,
    output logic             hit
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (srst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign hit = (cnt == dtop);

endmodule

// File: rtl/crank_wheel_gen.sv
// crank_wheel_gen: synthesises a toothed crank wheel signal (default 60-2)
// at a programmable, runtime-changeable slot period, for driving the HWAG
// capture/sync chain during bench and in-system self-test.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active-low
//   ena          in   run request; sampled only in IDLE and at slot ends
//   period       in   requested slot length in clk cycles
//   period_load  in   1-clk strobe, captures max(period, PERIOD_MIN) to shadow
//   tooth_out    out  wheel signal, high while a tooth is present
//   tooth_num    out  current slot index 0..TOOTH_NUM-1
//   rev_out      out  1-clk pulse on the rising edge of tooth 0
//   busy         out  generator running
module crank_wheel_gen #(
    parameter int PERIOD_WIDTH = hwag_pkg::PCNT_WIDTH,
    parameter int TCNT_WIDTH   = hwag_pkg::TCNT_WIDTH,
    parameter int TOOTH_NUM    = hwag_pkg::HWAG_TOOTH_NUM,
    parameter int GAP_TEETH    = hwag_pkg::HWAG_GAP_TEETH,
    parameter int PERIOD_MIN   = hwag_pkg::CWG_PERIOD_MIN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    period_load,
    output logic                    tooth_out,
    output logic [TCNT_WIDTH-1:0]   tooth_num,
    output logic                    rev_out,
    output logic                    busy
);

    import hwag_pkg::*;

    localparam logic [PERIOD_WIDTH-1:0] P_MIN     = PERIOD_WIDTH'(PERIOD_MIN);
    localparam logic [TCNT_WIDTH-1:0]   LAST_SLOT = TCNT_WIDTH'(TOOTH_NUM - 1);
    localparam logic [TCNT_WIDTH-1:0]   NUM_TEETH = TCNT_WIDTH'(TOOTH_NUM - GAP_TEETH);

    cwg_state_t              state;
    logic [PERIOD_WIDTH-1:0] shadow;
    logic [PERIOD_WIDTH-1:0] shadow_nxt;
    logic [PERIOD_WIDTH-1:0] active;
    logic [PERIOD_WIDTH-1:0] cnt;
    logic [PERIOD_WIDTH-1:0] dtop;
    logic [PERIOD_WIDTH-1:0] high_top;
    logic                    hit;
    logic                    hi_end;
    logic                    slot_end;
    logic                    timer_srst;
    logic [TCNT_WIDTH-1:0]   next_slot;

    // The shadow value that will be in force after this edge. Slot starts copy
    // this rather than the register so a load on the same clk governs the slot.
    assign shadow_nxt = period_load ? ((period < P_MIN) ? P_MIN : period) : shadow;

    assign dtop       = active - PERIOD_WIDTH'(1);
    assign high_top   = (active >> 1) - PERIOD_WIDTH'(1);
    assign hi_end     = (state == HIGH) && (cnt == high_top);
    assign slot_end   = ((state == LOW) || (state == GAP)) && hit;
    // Timer held at 0 while idle so slot 0 starts counting from 0.
    assign timer_srst = (state == IDLE) || slot_end;
    assign next_slot  = (tooth_num == LAST_SLOT) ? '0 : tooth_num + TCNT_WIDTH'(1);

    counter_compare #(
        .WIDTH (PERIOD_WIDTH)
    ) u_slot_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (state != IDLE),
        .srst (timer_srst),
        .dtop (dtop),
        .cnt  (cnt),
        .hit  (hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= P_MIN;
        end else begin
            shadow <= shadow_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            active    <= P_MIN;
            tooth_out <= 1'b0;
            tooth_num <= '0;
            rev_out   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rev_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (ena) begin
                        state     <= HIGH;
                        active    <= shadow_nxt;
                        tooth_out <= 1'b1;
                        tooth_num <= '0;
                        rev_out   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                HIGH: begin
                    if (hi_end) begin
                        state     <= LOW;
                        tooth_out <= 1'b0;
                    end
                end
                LOW, GAP: begin
                    // Slot end is the only place ena is honoured once running.
                    if (hit) begin
                        active <= shadow_nxt;
                        if (!ena) begin
                            state     <= IDLE;
                            tooth_out <= 1'b0;
                            tooth_num <= '0;
                            busy      <= 1'b0;
                        end else begin
                            tooth_num <= next_slot;
                            if (next_slot < NUM_TEETH) begin
                                state     <= HIGH;
                                tooth_out <= 1'b1;
                                rev_out   <= (next_slot == '0);
                            end else begin
                                state     <= GAP;
                                tooth_out <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Directed bench for crank_wheel_gen. Expected wheel events (rev pulse,
// tooth rise, tooth fall) with their clk index and slot number are queued
// before each run; a negedge monitor pops and compares them as they occur.
module tb_crank_wheel_gen;

    localparam int EV_REV  = 0;
    localparam int EV_RISE = 1;
    localparam int EV_FALL = 2;

    typedef struct {
        int kind;
        int cyc;
        int tn;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [23:0] period;
    logic        period_load;
    logic        tooth_out;
    logic [7:0]  tooth_num;
    logic        rev_out;
    logic        busy;

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];
    logic prev_t = 1'b0;

    crank_wheel_gen dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .period      (period),
        .period_load (period_load),
        .tooth_out   (tooth_out),
        .tooth_num   (tooth_num),
        .rev_out     (rev_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic got(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_event: observed kind %0d at cyc %0d slot %0d expected none",
                   kind, cyc, tooth_num);
        end else begin
            e = exp_q.pop_front();
            chk("ev_kind", kind, e.kind);
            chk("ev_cyc", cyc, e.cyc);
            chk("ev_slot", {24'd0, tooth_num}, e.tn);
        end
    endtask

    // Monitor order for a single clk: rev, then rise, then fall.
    always @(negedge clk) begin
        if (rev_out) got(EV_REV);
        if (tooth_out && !prev_t) got(EV_RISE);
        if (!tooth_out && prev_t) got(EV_FALL);
        prev_t = tooth_out;
    end

    // Queue the events of slots 0..last starting at clk s; slots before chg
    // last p0 clks, the rest p1. Returns the start of the last slot and the
    // first clk after it.
    task automatic push_slots(input int s, input int p0, input int p1, input int chg,
                              input int last, output int last_start, output int slot_end);
        int t, p, k;
        t = s;
        last_start = s;
        for (int j = 0; j <= last; j++) begin
            p = (j < chg) ? p0 : p1;
            k = j % 60;
            if (k == 0) exp_q.push_back('{EV_REV, t, 0});
            if (k < 58) begin
                exp_q.push_back('{EV_RISE, t, k});
                exp_q.push_back('{EV_FALL, t + p / 2, k});
            end
            if (j == last) last_start = t;
            t += p;
        end
        slot_end = t;
    endtask

    task automatic load(input int v);
        @(posedge clk); #1;
        period      = 24'(v);
        period_load = 1'b1;
        @(posedge clk); #1;
        period_load = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start from IDLE (by ena or by releasing reset with ena high), optionally
    // load p1 at clk s+load_rel, and drop ena 2 clks into the high phase of
    // slot `last` so the run stops cleanly after it.
    task automatic run(input int p0, input int p1, input int chg, input int load_rel,
                       input int last, input bit from_rst);
        int s, ls, se;
        s = cyc + 1;
        push_slots(s, p0, p1, chg, last, ls, se);
        if (from_rst) rst = 1'b1;
        else ena = 1'b1;
        while (cyc < se) begin
            @(posedge clk); #1;
            period_load = (load_rel >= 0) && (cyc == s + load_rel - 1);
            if (period_load) period = 24'(p1);
            if (cyc == ls + 1) ena = 1'b0;
            if (cyc == se - 1) begin
                chk("busy_last_clk", busy, 1);
                chk("low_at_slot_end", tooth_out, 0);
            end
        end
        chk("idle_busy", busy, 0);
        chk("idle_tooth_num", {24'd0, tooth_num}, 0);
        chk("idle_tooth_out", tooth_out, 0);
        chk("events_pending", exp_q.size(), 0);
        idle(4);
    endtask

    initial begin
        int s, ls, se;
        rst = 1'b0; ena = 1'b0; period = '0; period_load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tooth_out", tooth_out, 0);
        chk("rst_tooth_num", {24'd0, tooth_num}, 0);
        chk("rst_rev_out", rev_out, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        idle(2);
        chk("idle_no_ena_busy", busy, 0);

        // Constant periods, one full revolution plus slots 0..5.
        load(8); run(8, 8, 1000, -1, 65, 1'b0);
        load(9); run(9, 9, 1000, -1, 65, 1'b0);
        load(1); run(4, 4, 1000, -1, 65, 1'b0);

        // 8 -> 16 loaded mid-slot 10, then coincident with the slot-11 start.
        load(8); run(8, 16, 11, 83, 13, 1'b0);
        load(8); run(8, 16, 11, 88, 13, 1'b0);

        // Reset 3 clks into gap slot 58.
        load(8);
        s = cyc + 1;
        push_slots(s, 8, 8, 1000, 57, ls, se);
        ena = 1'b1;
        while (cyc < s + 58 * 8 + 3) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        chk("midrst_tooth_out", tooth_out, 0);
        chk("midrst_tooth_num", {24'd0, tooth_num}, 0);
        chk("midrst_rev_out", rev_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_events_pending", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_held_busy", busy, 0);
        // Period after reset must be PERIOD_MIN.
        run(4, 4, 1000, -1, 65, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
